// File: rtl/uart_tx_word_serializer.sv
// Word FIFO feeding a byte-at-a-time UART transmitter handshake.
// Words are sent least-significant byte first, paced on the transmitter's busy flag.
module uart_tx_word_serializer #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [8*WORD_BYTES-1:0]       in_data,
    output logic                          in_ready,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle
);

    localparam int DW = 8 * WORD_BYTES;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        ARM,
        DRAIN
    } stateT;

    stateT          state;
    logic [DW-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic [CW-1:0]  count;
    logic [DW-1:0]  sr;
    logic [BW-1:0]  byteIdx;
    logic           push;
    logic           pop;

    assign in_ready   = (count < DEPTH);
    assign push       = in_valid && in_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign fifo_count = count;
    assign idle       = (state == IDLE) && (count == '0) && !tx_busy;

    // Storage needs no reset: contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            byteIdx  <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        sr      <= mem[rdPtr];
                        byteIdx <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= sr[7:0];
                        state    <= ARM;
                    end
                end
                // Transmitter raises busy a cycle after the strobe; wait for it.
                ARM: begin
                    if (tx_busy) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (byteIdx == LAST_BYTE) begin
                            state <= IDLE;
                        end else begin
                            sr      <= sr >> 8;
                            byteIdx <= byteIdx + BW'(1);
                            state   <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Bench for uart_tx_word_serializer: transmitter model on the falling edge,
// byte-stream scoreboard, vector table and multi-cycle corner sequences.
module tb_uart_tx_word_serializer;

    localparam int WB = 4;
    localparam int FD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [3:0]  fifo_count;
    logic        idle;

    uart_tx_word_serializer #(.WORD_BYTES(WB), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Transmitter model: sees the strobe, raises busy one cycle later for busyLen cycles.
    logic [7:0] rxQ[$];
    int         rxCyc[$];
    int         rxGap[$];
    bit         rxViol[$];
    int         busyCnt = 0;
    int         busyLen = 10;
    int         lastFallCyc = 0;
    bit         armPending = 1'b0;
    bit         forceBusy = 1'b0;
    bit         randBusy = 1'b0;
    bit         prevStart = 1'b0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busyCnt > 0) busyCnt--;
            if (armPending) begin
                armPending = 1'b0;
                busyCnt = randBusy ? int'($urandom_range(1, 6)) : busyLen;
            end
            if (tx_start === 1'b1) begin
                rxQ.push_back(tx_data);
                rxCyc.push_back(cyc);
                rxGap.push_back(cyc - lastFallCyc);
                rxViol.push_back(prevStart || (tx_busy !== 1'b0));
                armPending = 1'b1;
            end
            prevStart = (tx_start === 1'b1);
            if (tx_busy && !(forceBusy || busyCnt > 0)) lastFallCyc = cyc;
            tx_busy = forceBusy || (busyCnt > 0);
        end
    end

    logic [7:0] expQ[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic queueWord(input logic [31:0] w);
        for (int k = 0; k < WB; k++) expQ.push_back(8'((w >> (8 * k)) & 32'hFF));
    endtask

    task automatic offer(input logic [31:0] w, input int maxCyc, output bit acc,
                         output int accCyc, output int cntAt, output int cntPrev);
        acc = 1'b0; accCyc = -1; cntAt = -1; cntPrev = -1;
        for (int i = 0; i < maxCyc && !acc; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            #1;
            if (in_ready === 1'b1) begin
                cntAt = int'(fifo_count);
                acc = 1'b1;
            end else begin
                cntPrev = int'(fifo_count);
            end
            @(posedge clk);
            #1;
            accCyc = cyc;
        end
        in_valid = 1'b0;
        if (acc) queueWord(w);
    endtask

    task automatic waitBytes(input int n, input int budget, input string name);
        int i = 0;
        while (rxQ.size() < n && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk({name, "_wait_bytes"}, rxQ.size(), n);
    endtask

    task automatic verifyStream(input int base, input string name);
        chk({name, "_len"}, rxQ.size() - base, expQ.size());
        for (int i = 0; i < expQ.size() && base + i < rxQ.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), rxQ[base + i], expQ[i]);
            chk($sformatf("%s_proto%0d", name, i), rxViol[base + i], 0);
        end
    endtask

    task automatic settle();
        int n = 0;
        while ((tx_busy || armPending || idle !== 1'b1) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("settle", (tx_busy || armPending || idle !== 1'b1), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [31:0]     word;
        int              busy;
        logic [0:3][7:0] seq;
    } vecT;

    vecT vecs[5];

    initial begin
        int base;
        int accCyc;
        int cntAt;
        int cntPrev;
        int nAcc;
        bit acc;

        vecs[0] = '{32'hDDCCBBAA, 10, {8'hAA, 8'hBB, 8'hCC, 8'hDD}};
        vecs[1] = '{32'h12345678, 5,  {8'h78, 8'h56, 8'h34, 8'h12}};
        vecs[2] = '{32'h00000000, 1,  {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{32'hFFFFFFFF, 2,  {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[4] = '{32'h80000001, 7,  {8'h01, 8'h00, 8'h00, 8'h80}};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_idle", idle, 1);

        // Single words from the vector table.
        for (int v = 0; v < 5; v++) begin
            busyLen = vecs[v].busy;
            base = rxQ.size();
            expQ.delete();
            offer(vecs[v].word, 10, acc, accCyc, cntAt, cntPrev);
            chk($sformatf("vec%0d_accept", v), acc, 1);
            waitBytes(base + 4, 500, $sformatf("vec%0d", v));
            if (rxQ.size() >= base + 4) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("vec%0d_byte%0d", v, k), rxQ[base + k], vecs[v].seq[k]);
                    if (k > 0) chk($sformatf("vec%0d_gap%0d", v, k), rxGap[base + k], 2);
                end
                chk($sformatf("vec%0d_first_latency", v), rxCyc[base] - accCyc, 2);
                for (int n = 0; n < 200 && lastFallCyc <= rxCyc[base + 3]; n++) begin
                    @(negedge clk);
                    #1;
                end
                @(negedge clk);
                #1;
                chk($sformatf("vec%0d_idle_after", v), idle, 1);
            end
            repeat (10) @(negedge clk);
            #1;
            chk($sformatf("vec%0d_pulse_count", v), rxQ.size() - base, 4);
            chk($sformatf("vec%0d_tx_data_hold", v), tx_data, vecs[v].seq[3]);
        end

        // FIFO full with busy held from reset, then push at the pop edge.
        settle();
        busyLen = 4;
        forceBusy = 1'b1;
        doReset();
        base = rxQ.size();
        expQ.delete();
        nAcc = 0;
        for (int i = 0; i < 10; i++) begin
            offer(32'hC0DE0000 + 32'(i), 3, acc, accCyc, cntAt, cntPrev);
            if (acc) nAcc++;
        end
        @(negedge clk);
        #1;
        chk("full_accepted", nAcc, 9);
        chk("full_in_ready", in_ready, 0);
        chk("full_fifo_count", fifo_count, 8);
        chk("full_no_start", rxQ.size() - base, 0);
        @(posedge clk);
        #1;
        forceBusy = 1'b0;
        offer(32'hFEEDF00D, 1000, acc, accCyc, cntAt, cntPrev);
        chk("poppush_accept", acc, 1);
        chk("poppush_count_before", cntPrev, 8);
        chk("poppush_count_at", cntAt, 7);
        @(negedge clk);
        #1;
        chk("poppush_count_after", fifo_count, 8);
        waitBytes(base + 40, 3000, "full");
        verifyStream(base, "full");
        if (rxQ.size() >= base + 40) begin
            chk("full_gap0", rxGap[base], 1);
            for (int i = 1; i < 40; i++)
                chk($sformatf("full_gap%0d", i), rxGap[base + i], (i % 4 == 0) ? 3 : 2);
        end

        // Pointer wrap: 20 incrementing words at full rate.
        settle();
        doReset();
        busyLen = 3;
        base = rxQ.size();
        expQ.delete();
        nAcc = 0;
        for (int i = 1; i <= 20; i++) begin
            offer(32'(i), 200, acc, accCyc, cntAt, cntPrev);
            if (acc) nAcc++;
        end
        chk("wrap_accepted", nAcc, 20);
        waitBytes(base + 80, 5000, "wrap");
        verifyStream(base, "wrap");

        // Reset after the second byte's strobe.
        settle();
        busyLen = 10;
        base = rxQ.size();
        expQ.delete();
        offer(32'h11223344, 10, acc, accCyc, cntAt, cntPrev);
        offer(32'h55667788, 10, acc, accCyc, cntAt, cntPrev);
        waitBytes(base + 2, 300, "midrst");
        chk("midrst_start_high", tx_start, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_fifo_count", fifo_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("midrst_no_pulses", rxQ.size() - base, 2);
        base = rxQ.size();
        expQ.delete();
        offer(32'hCAFEBABE, 10, acc, accCyc, cntAt, cntPrev);
        waitBytes(base + 4, 500, "midrst_new");
        verifyStream(base, "midrst_new");
        if (rxQ.size() > base) chk("midrst_new_gap", rxGap[base], 1);

        // Transmitter already busy when the word arrives.
        settle();
        forceBusy = 1'b1;
        @(negedge clk);
        #1;
        base = rxQ.size();
        expQ.delete();
        offer(32'h0BADBEEF, 10, acc, accCyc, cntAt, cntPrev);
        repeat (10) @(negedge clk);
        #1;
        chk("busy_no_start", rxQ.size() - base, 0);
        chk("busy_idle", idle, 0);
        chk("busy_fifo_count", fifo_count, 0);
        @(posedge clk);
        #1;
        forceBusy = 1'b0;
        waitBytes(base + 4, 500, "busy");
        if (rxQ.size() > base) chk("busy_release_gap", rxGap[base], 1);
        verifyStream(base, "busy");

        // Randomized words, gaps and busy lengths against the byte-stream model.
        settle();
        randBusy = 1'b1;
        base = rxQ.size();
        expQ.delete();
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            offer($urandom(), 500, acc, accCyc, cntAt, cntPrev);
        end
        waitBytes(base + expQ.size(), 20000, "rand");
        verifyStream(base, "rand");
        randBusy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
